// File: rtl/cpu_6502_rmw_unit_if.sv
// Bus and ALU signal bundle between the RMW sequencer (master) and the
// bus arbiter / CPU ALU (slave). Field names are from the sequencer's view.
interface cpu_6502_rmw_unit_if #(parameter int ADDR_W = 16);
  logic [ADDR_W-1:0] o_bus_addr;
  logic              o_bus_wr;
  logic [7:0]        o_bus_wdata;
  logic [7:0]        i_bus_rdata;
  logic              i_bus_rdy;
  logic [3:0]        o_alu_func;
  logic [7:0]        o_alu_left;
  logic [7:0]        o_alu_right;
  logic              o_alu_c;
  logic [7:0]        i_alu_q;
  logic              i_alu_c;
  logic              i_alu_z;
  logic              i_alu_n;

  modport master (
    output o_bus_addr, o_bus_wr, o_bus_wdata, o_alu_func, o_alu_left, o_alu_right, o_alu_c,
    input  i_bus_rdata, i_bus_rdy, i_alu_q, i_alu_c, i_alu_z, i_alu_n
  );
  modport slave (
    input  o_bus_addr, o_bus_wr, o_bus_wdata, o_alu_func, o_alu_left, o_alu_right, o_alu_c,
    output i_bus_rdata, i_bus_rdy, i_alu_q, i_alu_c, i_alu_z, i_alu_n
  );
endinterface

// File: rtl/cpu_6502_rmw_unit.sv
// Read / dummy-write / final-write sequencer for 2A03 memory RMW instructions.
// Bus outputs are registered; the ALU is fed from the captured operand during DUMMY.
module cpu_6502_rmw_unit #(
  parameter int ADDR_W   = 16,
  parameter bit DUMMY_WR = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [2:0]        i_op,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_c,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_flag_we,
  output logic              o_flag_c_we,
  output logic              o_flag_c,
  output logic              o_flag_z,
  output logic              o_flag_n,
  cpu_6502_rmw_unit_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DUMMY, S_WRITE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        data_q, data_d;
  logic [2:0]        op_q, op_d;
  logic              c_q, c_d;
  logic              done_q, done_d;
  logic              cwe_q, cwe_d;
  logic              fc_q, fc_d, fz_q, fz_d, fn_q, fn_d;
  logic              accept;

  assign accept = i_start && (i_op <= 3'd5);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // every transition waits for the bus to be ready
  always_comb begin
    state_d = state_q;
    if (bus.i_bus_rdy) begin
      case (state_q)
        S_IDLE:  if (accept) state_d = S_READ;
        S_READ:  state_d = S_DUMMY;
        S_DUMMY: state_d = S_WRITE;
        S_WRITE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    op_d    = op_q;
    c_d     = c_q;
    fc_d    = fc_q;
    fz_d    = fz_q;
    fn_d    = fn_q;
    done_d  = 1'b0;
    cwe_d   = 1'b0;
    if (bus.i_bus_rdy) begin
      case (state_q)
        S_IDLE: if (accept) begin
          addr_d = i_addr;
          op_d   = i_op;
          c_d    = i_c;
          wr_d   = 1'b0;
        end
        S_READ: begin
          data_d  = bus.i_bus_rdata;
          wr_d    = DUMMY_WR;
          wdata_d = DUMMY_WR ? bus.i_bus_rdata : wdata_q;
        end
        // the write-data register doubles as the result register
        S_DUMMY: begin
          wdata_d = bus.i_alu_q;
          fc_d    = bus.i_alu_c;
          fz_d    = bus.i_alu_z;
          fn_d    = bus.i_alu_n;
          wr_d    = 1'b1;
        end
        S_WRITE: begin
          wr_d   = 1'b0;
          done_d = 1'b1;
          cwe_d  = ~op_q[2];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= 8'h00;
      data_q  <= 8'h00;
      op_q    <= 3'd0;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
      cwe_q   <= 1'b0;
      fc_q    <= 1'b0;
      fz_q    <= 1'b0;
      fn_q    <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      op_q    <= op_d;
      c_q     <= c_d;
      done_q  <= done_d;
      cwe_q   <= cwe_d;
      fc_q    <= fc_d;
      fz_q    <= fz_d;
      fn_q    <= fn_d;
    end
  end

  always_comb begin
    bus.o_alu_func = 4'hF;
    if (state_q != S_IDLE) begin
      case (op_q)
        3'd0:    bus.o_alu_func = 4'h8;
        3'd1:    bus.o_alu_func = 4'h9;
        3'd2:    bus.o_alu_func = 4'hA;
        3'd3:    bus.o_alu_func = 4'hB;
        3'd4:    bus.o_alu_func = 4'h5;
        3'd5:    bus.o_alu_func = 4'h7;
        default: bus.o_alu_func = 4'hF;
      endcase
    end
  end

  assign bus.o_alu_left  = data_q;
  assign bus.o_alu_right = 8'h00;
  assign bus.o_alu_c     = c_q;
  assign bus.o_bus_addr  = addr_q;
  assign bus.o_bus_wr    = wr_q;
  assign bus.o_bus_wdata = wdata_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = done_q;
  assign o_flag_we   = done_q;
  assign o_flag_c_we = cwe_q;
  assign o_flag_c    = fc_q;
  assign o_flag_z    = fz_q;
  assign o_flag_n    = fn_q;
endmodule

// File: tb/tb_cpu_6502_rmw_unit.sv
// Self-checking bench: bus memory + ALU model around two builds (dummy write on/off),
// directed timing cases plus randomized ops against an arithmetic reference.
module tb_cpu_6502_rmw_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] q; logic c; logic z; logic n; } res_t;
  typedef struct { logic wr; logic [15:0] a; logic [7:0] d; } xfer_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CPU ALU stand-in: {n,z,c,q}
  function automatic logic [10:0] alu_f(input logic [3:0] f, input logic [7:0] l, input logic ci);
    logic [7:0] q; logic c;
    q = l; c = ci;
    case (f)
      4'h8: {c, q} = {l, 1'b0};
      4'h9: begin q = {1'b0, l[7:1]}; c = l[0]; end
      4'hA: {c, q} = {l, ci};
      4'hB: begin q = {ci, l[7:1]}; c = l[0]; end
      4'h5: {c, q} = {1'b0, l} + 9'd1;
      4'h7: q = l - 8'd1;
      default: ;
    endcase
    return {q[7], (q == 8'h00), c, q};
  endfunction

  // reference result from the instruction definitions, plain integer arithmetic
  function automatic res_t ref_rmw(input int op, input int m, input int ci);
    int q; int c; res_t r;
    c = 0;
    case (op)
      0: begin q = (m * 2) % 256;      c = m / 128; end
      1: begin q = m / 2;              c = m % 2;   end
      2: begin q = (m * 2 + ci) % 256; c = m / 128; end
      3: begin q = m / 2 + ci * 128;   c = m % 2;   end
      4: q = (m + 1) % 256;
      5: q = (m + 255) % 256;
      default: q = m;
    endcase
    r.q = q[7:0]; r.c = c[0]; r.z = (q == 0); r.n = (q >= 128);
    return r;
  endfunction

  // ---------------- DUT 1: dummy write of old value ----------------
  logic start, cin, busy, done, fwe, fcwe, fc, fz, fn;
  logic [2:0] op;
  logic [15:0] addr;
  cpu_6502_rmw_unit_if #(.ADDR_W(16)) bif();

  cpu_6502_rmw_unit #(.ADDR_W(16), .DUMMY_WR(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_addr(addr), .i_c(cin),
    .o_busy(busy), .o_done(done), .o_flag_we(fwe), .o_flag_c_we(fcwe),
    .o_flag_c(fc), .o_flag_z(fz), .o_flag_n(fn), .bus(bif)
  );

  logic [7:0] mem [0:65535];
  logic rnd_en, rnd_rdy, rdy_f, seed_en;
  logic [15:0] seed_a;
  logic [7:0] seed_d;
  xfer_t log_q[$];

  assign bif.i_bus_rdata = mem[bif.o_bus_addr];
  assign bif.i_bus_rdy   = rnd_en ? rnd_rdy : rdy_f;
  assign {bif.i_alu_n, bif.i_alu_z, bif.i_alu_c, bif.i_alu_q} = alu_f(bif.o_alu_func, bif.o_alu_left, bif.o_alu_c);

  always @(negedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);

  always @(posedge clk) begin
    if (seed_en) mem[seed_a] <= seed_d;
    if (!rst && bif.i_bus_rdy && busy) begin
      log_q.push_back('{bif.o_bus_wr, bif.o_bus_addr, bif.o_bus_wdata});
      if (bif.o_bus_wr) mem[bif.o_bus_addr] <= bif.o_bus_wdata;
    end
  end

  // ---------------- DUT 2: dummy cycle re-reads ----------------
  logic start2, busy2, done2, fwe2, fcwe2, fc2, fz2, fn2;
  logic [7:0] r2;
  xfer_t log2[$];
  cpu_6502_rmw_unit_if #(.ADDR_W(16)) bif2();

  cpu_6502_rmw_unit #(.ADDR_W(16), .DUMMY_WR(1'b0)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_op(3'd0), .i_addr(16'h0123), .i_c(1'b0),
    .o_busy(busy2), .o_done(done2), .o_flag_we(fwe2), .o_flag_c_we(fcwe2),
    .o_flag_c(fc2), .o_flag_z(fz2), .o_flag_n(fn2), .bus(bif2)
  );

  assign bif2.i_bus_rdata = r2;
  assign bif2.i_bus_rdy   = 1'b1;
  assign {bif2.i_alu_n, bif2.i_alu_z, bif2.i_alu_c, bif2.i_alu_q} = alu_f(bif2.o_alu_func, bif2.o_alu_left, bif2.o_alu_c);

  always @(posedge clk)
    if (!rst && busy2) log2.push_back('{bif2.o_bus_wr, bif2.o_bus_addr, bif2.o_bus_wdata});

  // ---------------- checks ----------------
  task automatic check_done(input string tag, input int o, input res_t e, input logic [15:0] a);
    chk({tag, "_fwe"}, fwe, 1'b1);
    chk({tag, "_cwe"}, fcwe, (o <= 3));
    chk({tag, "_z"}, fz, e.z);
    chk({tag, "_n"}, fn, e.n);
    if (o <= 3) chk({tag, "_c"}, fc, e.c);
    chk({tag, "_mem"}, mem[a], e.q);
  endtask

  task automatic check_log(input string tag, input logic [15:0] a, input logic [7:0] m, input logic [7:0] q);
    chk({tag, "_nxfer"}, log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk({tag, "_rd"}, {log_q[0].wr, log_q[0].a}, {1'b0, a});
      chk({tag, "_dwr"}, {log_q[1].wr, log_q[1].a, log_q[1].d}, {1'b1, a, m});
      chk({tag, "_fwr"}, {log_q[2].wr, log_q[2].a, log_q[2].d}, {1'b1, a, q});
    end
  endtask

  // pat bit k = bus ready during cycle k, start sampled at cycle 0
  task automatic run_timed(input string tag, input int o, input logic [15:0] a, input logic ci,
                           input logic [7:0] m, input logic [15:0] pat, input int exp_cyc);
    res_t e; int dcyc; int ndone;
    e = ref_rmw(o, m, ci);
    dcyc = -1; ndone = 0;
    log_q.delete();
    @(negedge clk);
    rnd_en = 1'b0; rdy_f = pat[0];
    seed_en = 1'b1; seed_a = a; seed_d = m;
    start = 1'b1; op = o[2:0]; addr = a; cin = ci;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      seed_en = 1'b0; start = 1'b0; rdy_f = pat[cyc];
      if (cyc == 3) chk({tag, "_hold"}, {busy, bif.o_bus_addr}, {1'b1, a});
      if (done) begin
        ndone++;
        if (dcyc < 0) begin dcyc = cyc; check_done(tag, o, e, a); end
      end
    end
    rdy_f = 1'b1;
    chk({tag, "_donecyc"}, dcyc, exp_cyc);
    chk({tag, "_ndone"}, ndone, 1);
    check_log(tag, a, m, e.q);
  endtask

  task automatic run_rand(input int idx);
    int o; logic [15:0] a; logic ci; logic [7:0] m; res_t e; bit ok;
    o = $urandom_range(0, 5); a = 16'($urandom); ci = 1'($urandom); m = 8'($urandom);
    e = ref_rmw(o, m, ci);
    log_q.delete();
    @(negedge clk);
    rnd_en = 1'b1;
    seed_en = 1'b1; seed_a = a; seed_d = m;
    start = 1'b1; op = o[2:0]; addr = a; cin = ci;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      seed_en = 1'b0;
      if (busy) ok = 1'b1;
    end
    start = 1'b0;
    chk($sformatf("rnd%0d_accept", idx), ok, 1'b1);
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    chk($sformatf("rnd%0d_done", idx), ok, 1'b1);
    if (ok) begin
      check_done($sformatf("rnd%0d", idx), o, e, a);
      check_log($sformatf("rnd%0d", idx), a, m, e.q);
    end
    rnd_en = 1'b0;
  endtask

  initial begin
    int cnt; bit seen;
    rst = 1'b1; start = 1'b0; op = 3'd0; addr = 16'h0; cin = 1'b0;
    rnd_en = 1'b0; rdy_f = 1'b1; seed_en = 1'b0; seed_a = 16'h0; seed_d = 8'h0;
    start2 = 1'b0; r2 = 8'h81;
    #12;
    chk("rst_ctl", {busy, done, fwe, fcwe, fc, fz, fn}, 7'b0);
    chk("rst_bus", {bif.o_bus_wr, bif.o_bus_addr, bif.o_bus_wdata}, 25'h0);
    chk("rst_alu", {bif.o_alu_func, bif.o_alu_left, bif.o_alu_right}, {4'hF, 16'h0});
    @(negedge clk); rst = 1'b0;

    run_timed("asl80", 0, 16'h0200, 1'b0, 8'h80, 16'hFFFF, 4);
    run_timed("ror01", 3, 16'h0210, 1'b1, 8'h01, 16'hFFFF, 4);
    run_timed("rol40", 2, 16'h0220, 1'b0, 8'h40, 16'hFFFF, 4);
    run_timed("lsr03", 1, 16'h0230, 1'b1, 8'h03, 16'hFFFF, 4);
    run_timed("incff", 4, 16'h0240, 1'b0, 8'hFF, 16'hFFFF, 4);
    run_timed("dec00", 5, 16'h0241, 1'b1, 8'h00, 16'hFFFF, 4);
    run_timed("stall", 4, 16'h0250, 1'b0, 8'h3C, 16'hFF31, 9);

    // illegal op: no bus activity
    log_q.delete(); seen = 1'b0;
    @(negedge clk); start = 1'b1; op = 3'd6; addr = 16'h0260;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); start = 1'b0;
      if (busy) seen = 1'b1;
    end
    chk("ill_busy", seen, 1'b0);
    chk("ill_xfer", log_q.size(), 0);

    // second start while busy is dropped
    log_q.delete(); cnt = 0;
    @(negedge clk); seed_en = 1'b1; seed_a = 16'h0270; seed_d = 8'h10;
    start = 1'b1; op = 3'd5; addr = 16'h0270;
    @(negedge clk); seed_en = 1'b0; start = 1'b0;
    @(negedge clk); start = 1'b1; op = 3'd4; addr = 16'h0280;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); start = 1'b0;
      if (done) cnt++;
    end
    chk("busy_ndone", cnt, 1);
    chk("busy_mem", mem[16'h0270], 8'h0F);
    cnt = 0;
    foreach (log_q[i]) if (log_q[i].a != 16'h0270) cnt++;
    chk("busy_addr", cnt, 0);

    // reset in DUMMY aborts the op
    log_q.delete(); cnt = 0;
    @(negedge clk); seed_en = 1'b1; seed_a = 16'h0290; seed_d = 8'h55;
    start = 1'b1; op = 3'd0; addr = 16'h0290;
    @(negedge clk); seed_en = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rstmid_dwr", bif.o_bus_wr, 1'b1);
    #1 rst = 1'b1;
    #1 chk("rstmid_wr", {bif.o_bus_wr, busy}, 2'b00);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || fwe) cnt++;
    end
    chk("rstmid_nodone", cnt, 0);
    chk("rstmid_mem", mem[16'h0290], 8'h55);
    run_timed("postrst", 4, 16'h02A0, 1'b0, 8'h7F, 16'hFFFF, 4);

    // re-read build
    log2.delete(); cnt = 0;
    @(negedge clk); start2 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); start2 = 1'b0;
      if (done2) begin
        cnt++;
        chk("nodw_done", k, 4);
        chk("nodw_flags", {fwe2, fcwe2, fc2, fz2, fn2}, 5'b11100);
      end
    end
    chk("nodw_ndone", cnt, 1);
    chk("nodw_busy", busy2, 1'b0);
    chk("nodw_nxfer", log2.size(), 3);
    if (log2.size() == 3) begin
      chk("nodw_rd0", {log2[0].wr, log2[0].a}, {1'b0, 16'h0123});
      chk("nodw_rd1", {log2[1].wr, log2[1].a}, {1'b0, 16'h0123});
      chk("nodw_wr", {log2[2].wr, log2[2].a, log2[2].d}, {1'b1, 16'h0123, 8'h02});
    end

    for (int i = 0; i < 40; i++) run_rand(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
